// File: rtl/shadowmask_loader.sv
// Mask-file loader for the shadow-mask stage: buffers an ioctl download, validates it and
// replays it as the 16-bit command stream, re-issuing the control word on OSD changes.
module shadowmask_loader #(
  parameter int unsigned CMD_GAP = 0,
  parameter logic [15:0] MAGIC   = 16'h534D
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic        osd_enable,
  input  logic        osd_rotate,
  output logic        cmd_wr,
  output logic [15:0] cmd_out,
  output logic        busy,
  output logic        load_error,
  output logic        mask_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  localparam logic [6:0] LAST_CMD = 7'd71;
  localparam logic [3:0] GAP      = 4'(CMD_GAP);

  logic [1:0]  state;
  logic        dl_prev;
  logic [15:0] file_buf [0:18];
  logic [18:0] recv_mask;
  logic [6:0]  cmd_idx;
  logic [3:0]  gap_cnt;
  logic [1:0]  last_sent;

  logic        dl_rise;
  logic        dl_fall;
  logic        wr_ok;
  logic [4:0]  wr_idx;
  logic [18:0] wr_bit;
  logic        file_ok;
  logic [1:0]  osd_now;
  logic        refresh;
  logic        rot;
  logic [5:0]  lut_n;
  logic [15:0] lut_word;
  logic [3:0]  lut_val;
  logic [15:0] ctrl_final;
  logic [15:0] cmd_word;

  assign dl_rise = ioctl_download & ~dl_prev;
  assign dl_fall = ~ioctl_download & dl_prev;
  assign wr_ok   = ioctl_download & ioctl_wr & (ioctl_addr < 8'd38);
  assign wr_idx  = ioctl_addr[5:1];
  assign wr_bit  = wr_ok ? (19'd1 << wr_idx) : 19'd0;
  assign file_ok = (file_buf[0] == MAGIC) && (&recv_mask);
  assign osd_now = {osd_enable, osd_rotate};
  // A new download outranks a pending control refresh.
  assign refresh = (state == S_IDLE) && mask_valid && (osd_now != last_sent) && !dl_rise;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk_sys) begin
    if (wr_ok) file_buf[wr_idx] <= ioctl_dout;
  end

  always_comb begin
    rot        = file_buf[1][9] ^ osd_rotate;
    ctrl_final = {13'b0, rot, file_buf[1][8], osd_enable};
    lut_n      = cmd_idx[5:0] - 6'd7;
    lut_word   = file_buf[5'd3 + {1'b0, lut_n[5:2]}];
    case (lut_n[1:0])
      2'd0:    lut_val = lut_word[3:0];
      2'd1:    lut_val = lut_word[7:4];
      2'd2:    lut_val = lut_word[11:8];
      default: lut_val = lut_word[15:12];
    endcase
    // The opening control word forces the mask off while the tables are rewritten.
    case (cmd_idx)
      7'd0:     cmd_word = {13'b0, rot, file_buf[1][8], 1'b0};
      7'd1:     cmd_word = {3'b001, 9'b0, file_buf[1][7:4]};
      7'd2:     cmd_word = {3'b010, 9'b0, file_buf[1][3:0]};
      7'd3:     cmd_word = {3'b100, 10'b0, file_buf[2][2:0]};
      7'd4:     cmd_word = {3'b100, 8'b0, 2'b10, file_buf[2][5:3]};
      7'd5:     cmd_word = {3'b101, 9'b0, file_buf[2][11:8]};
      7'd6:     cmd_word = {3'b101, 8'b0, 1'b1, file_buf[2][15:12]};
      LAST_CMD: cmd_word = ctrl_final;
      default:  cmd_word = {3'b011, 3'b0, lut_n, lut_val};
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      dl_prev    <= 1'b0;
      recv_mask  <= 19'd0;
      cmd_idx    <= 7'd0;
      gap_cnt    <= 4'd0;
      last_sent  <= 2'b00;
      cmd_wr     <= 1'b0;
      cmd_out    <= 16'd0;
      load_error <= 1'b0;
      mask_valid <= 1'b0;
    end else begin
      dl_prev   <= ioctl_download;
      cmd_wr    <= 1'b0;
      recv_mask <= (dl_rise ? 19'd0 : recv_mask) | wr_bit;
      case (state)
        S_IDLE: begin
          if (dl_rise) begin
            state      <= S_RECV;
            load_error <= 1'b0;
            cmd_idx    <= 7'd0;
          end else if (refresh) begin
            cmd_wr    <= 1'b1;
            cmd_out   <= ctrl_final;
            last_sent <= osd_now;
          end
        end
        S_RECV: begin
          if (dl_fall) state <= S_CHECK;
        end
        S_CHECK: begin
          if (file_ok) begin
            cmd_wr  <= 1'b1;
            cmd_out <= cmd_word;
            cmd_idx <= 7'd1;
            gap_cnt <= GAP;
            state   <= S_SEND;
          end else begin
            load_error <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_SEND: begin
          // The final word samples the OSD live, so changes during the send are absorbed here.
          if (dl_rise) begin
            state      <= S_RECV;
            mask_valid <= 1'b0;
            load_error <= 1'b0;
            cmd_idx    <= 7'd0;
          end else if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
          end else begin
            cmd_wr  <= 1'b1;
            cmd_out <= cmd_word;
            gap_cnt <= GAP;
            if (cmd_idx == LAST_CMD) begin
              state      <= S_IDLE;
              mask_valid <= 1'b1;
              last_sent  <= osd_now;
              cmd_idx    <= 7'd0;
            end else begin
              cmd_idx <= cmd_idx + 7'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shadowmask_loader.sv
// Bench for shadowmask_loader: a no-gap and a gap-of-3 instance share the ioctl/OSD stimulus,
// and both command streams are checked against a file-level model of the expected commands.
module tb_shadowmask_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        osd_enable;
  logic        osd_rotate;
  logic        cmd_wr0, cmd_wr3;
  logic [15:0] cmd_out0, cmd_out3;
  logic        busy0, busy3, load_error0, load_error3, mask_valid0, mask_valid3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt0, cnt3, first0, first3, last0, last3, fall_cyc, saved3;
  bit gap_chk = 1'b0;
  logic [15:0] q0[$];
  logic [15:0] q3[$];
  logic [15:0] log0[$];
  logic [15:0] file_w [0:18];
  logic [15:0] exp0, exp3;

  shadowmask_loader #(.CMD_GAP(0), .MAGIC(16'h534D)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .osd_enable(osd_enable), .osd_rotate(osd_rotate), .cmd_wr(cmd_wr0),
    .cmd_out(cmd_out0), .busy(busy0), .load_error(load_error0), .mask_valid(mask_valid0)
  );

  shadowmask_loader #(.CMD_GAP(3), .MAGIC(16'h534D)) dut3 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .osd_enable(osd_enable), .osd_rotate(osd_rotate), .cmd_wr(cmd_wr3),
    .cmd_out(cmd_out3), .busy(busy3), .load_error(load_error3), .mask_valid(mask_valid3)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every strobe must match the head of that instance's expected queue.
  always @(negedge clk_sys) begin
    if (cmd_wr0) begin
      log0.push_back(cmd_out0);
      if (cnt0 == 0) first0 = cyc;
      last0 = cyc;
      cnt0++;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_cmd0: got 0x%h, expected no strobe", cmd_out0);
      end else begin
        exp0 = q0.pop_front();
        check_output("cmd_stream0", cmd_out0, exp0);
      end
    end
    if (cmd_wr3) begin
      if (gap_chk && cnt3 > 0) check_output("gap3_spacing", cyc - last3, 4);
      if (cnt3 == 0) first3 = cyc;
      last3 = cyc;
      cnt3++;
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_cmd3: got 0x%h, expected no strobe", cmd_out3);
      end else begin
        exp3 = q3.pop_front();
        check_output("cmd_stream3", cmd_out3, exp3);
      end
    end
  end

  task automatic push_both(input int v);
    q0.push_back(16'(v));
    q3.push_back(16'(v));
  endtask

  function automatic int final_ctrl();
    int w1;
    w1 = int'(file_w[1]);
    return ((((w1 >> 9) & 1) ^ int'(osd_rotate)) * 4) + ((w1 >> 8) & 1) * 2 + int'(osd_enable);
  endfunction

  // Expected 72-command replay derived from the file layout and the current OSD setting.
  task automatic expect_file();
    int w1, w2, rot, x2, e;
    w1  = int'(file_w[1]);
    w2  = int'(file_w[2]);
    rot = ((w1 >> 9) & 1) ^ int'(osd_rotate);
    x2  = (w1 >> 8) & 1;
    push_both(rot * 4 + x2 * 2);
    push_both(1 * 8192 + ((w1 >> 4) & 15));
    push_both(2 * 8192 + (w1 & 15));
    push_both(4 * 8192 + (w2 & 7));
    push_both(4 * 8192 + 16 + ((w2 >> 3) & 7));
    push_both(5 * 8192 + ((w2 >> 8) & 15));
    push_both(5 * 8192 + 16 + ((w2 >> 12) & 15));
    for (int n = 0; n < 64; n++) begin
      e = (int'(file_w[3 + n / 4]) >> (4 * (n % 4))) & 15;
      push_both(3 * 8192 + n * 16 + e);
    end
    push_both(final_ctrl());
  endtask

  task automatic build_file();
    logic [15:0] w;
    file_w[0] = 16'h534D;
    file_w[1] = 16'h0123;
    file_w[2] = 16'h9A2B;
    for (int k = 0; k < 16; k++) begin
      w = 16'h0000;
      for (int j = 0; j < 4; j++) w = w | 16'(((4 * k + j) % 16) << (4 * j));
      file_w[3 + k] = w;
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < log0.size()) return log0[i];
    return 16'hxxxx;
  endfunction

  task automatic clear_counters();
    cnt0 = 0; cnt3 = 0; first0 = 0; first3 = 0; last0 = 0; last3 = 0;
    log0.delete();
  endtask

  // Download the file, skipping one word if skip_word is in range, plus two writes that must be ignored.
  task automatic apply_stimulus(input int skip_word);
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 19; i++) begin
      if (i != skip_word) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 8'(2 * i);
        ioctl_dout = file_w[i];
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
      end
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = 8'h42;
    ioctl_dout = 16'hFFFF;
    @(negedge clk_sys);
    ioctl_addr = 8'h26;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_sys);
      #1;
      if (!busy0 && !busy3 && q0.size() == 0 && q3.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check_output("done_within_budget", done, 1);
    check_output("pending_cmds0", q0.size(), 0);
    check_output("pending_cmds3", q3.size(), 0);
  endtask

  task automatic wait_strobes0(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_sys);
      #1;
      if (cnt0 >= target) break;
    end
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_cmd_wr0"}, cmd_wr0, 0);
    check_output({tag, "_cmd_out0"}, cmd_out0, 0);
    check_output({tag, "_busy0"}, busy0, 0);
    check_output({tag, "_load_error0"}, load_error0, 0);
    check_output({tag, "_mask_valid0"}, mask_valid0, 0);
    check_output({tag, "_cmd_wr3"}, cmd_wr3, 0);
    check_output({tag, "_cmd_out3"}, cmd_out3, 0);
    check_output({tag, "_busy3"}, busy3, 0);
    check_output({tag, "_load_error3"}, load_error3, 0);
    check_output({tag, "_mask_valid3"}, mask_valid3, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = 8'h00;
    ioctl_dout = 16'h0000; osd_enable = 1'b0; osd_rotate = 1'b0;
    build_file();
    clear_counters();
    @(negedge clk_sys);
    #1;
    check_idle("reset");
    @(negedge clk_sys);
    reset_n = 1'b1;

    // OSD changes before any valid load must stay silent
    @(negedge clk_sys);
    osd_enable = 1'b1;
    repeat (5) @(negedge clk_sys);
    #1;
    check_output("no_refresh_unloaded0", cnt0, 0);
    check_output("no_refresh_unloaded3", cnt3, 0);

    $display("[TB] valid download");
    clear_counters();
    gap_chk = 1'b1;
    expect_file();
    apply_stimulus(-1);
    wait_done(400);
    gap_chk = 1'b0;
    check_output("count0", cnt0, 72);
    check_output("count3", cnt3, 72);
    check_output("latency0", first0 - fall_cyc, 2);
    check_output("latency3", first3 - fall_cyc, 2);
    check_output("span0", last0 - first0, 71);
    check_output("span3", last3 - first3, 284);
    check_output("lit_cmd1", log_at(0), 16'h0002);
    check_output("lit_cmd2", log_at(1), 16'h2002);
    check_output("lit_cmd3", log_at(2), 16'h4003);
    check_output("lit_cmd4", log_at(3), 16'h8003);
    check_output("lit_cmd5", log_at(4), 16'h8015);
    check_output("lit_cmd6", log_at(5), 16'hA00A);
    check_output("lit_cmd7", log_at(6), 16'hA019);
    check_output("lit_lut5", log_at(12), 16'h6055);
    check_output("lit_final", log_at(71), 16'h0003);
    check_output("mask_valid0_after_load", mask_valid0, 1);
    check_output("mask_valid3_after_load", mask_valid3, 1);
    check_output("load_error0_after_load", load_error0, 0);

    $display("[TB] control refresh");
    clear_counters();
    @(negedge clk_sys);
    osd_rotate = 1'b1;
    push_both(final_ctrl());
    repeat (4) @(negedge clk_sys);
    #1;
    check_output("refresh_count0", cnt0, 1);
    check_output("refresh_count3", cnt3, 1);
    check_output("lit_refresh", log_at(0), 16'h0007);
    repeat (10) @(negedge clk_sys);
    #1;
    check_output("steady_osd_count0", cnt0, 1);
    check_output("steady_osd_count3", cnt3, 1);
    // write to w1 with download low must not reach the buffer
    @(negedge clk_sys);
    ioctl_wr = 1'b1; ioctl_addr = 8'h02; ioctl_dout = 16'h0000;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    osd_rotate = 1'b0;
    push_both(final_ctrl());
    repeat (4) @(negedge clk_sys);
    #1;
    check_output("refresh2_count0", cnt0, 2);
    check_output("lit_refresh2", log_at(1), 16'h0003);

    $display("[TB] bad magic");
    clear_counters();
    file_w[0] = 16'h1234;
    apply_stimulus(-1);
    @(negedge clk_sys);
    #1;
    check_output("badmagic_busy_check", busy0, 1);
    @(negedge clk_sys);
    #1;
    check_output("badmagic_busy0", busy0, 0);
    check_output("badmagic_load_error0", load_error0, 1);
    check_output("badmagic_busy3", busy3, 0);
    check_output("badmagic_load_error3", load_error3, 1);
    check_output("badmagic_mask_valid_kept", mask_valid0, 1);
    repeat (5) @(negedge clk_sys);
    #1;
    check_output("badmagic_count0", cnt0, 0);
    check_output("badmagic_count3", cnt3, 0);
    file_w[0] = 16'h534D;

    $display("[TB] short file");
    clear_counters();
    apply_stimulus(18);
    #1;
    check_output("short_error_cleared", load_error0, 0);
    repeat (2) @(negedge clk_sys);
    #1;
    check_output("short_load_error0", load_error0, 1);
    check_output("short_load_error3", load_error3, 1);
    check_output("short_busy0", busy0, 0);
    repeat (5) @(negedge clk_sys);
    #1;
    check_output("short_count0", cnt0, 0);
    check_output("short_count3", cnt3, 0);

    $display("[TB] abort mid-LUT");
    clear_counters();
    expect_file();
    apply_stimulus(-1);
    wait_strobes0(28, 200);
    check_output("abort_point", cnt0, 28);
    check_output("lit_lut20", log_at(27), 16'h6144);
    ioctl_download = 1'b1;
    q0.delete();
    q3.delete();
    saved3 = cnt3;
    repeat (10) @(negedge clk_sys);
    #1;
    check_output("abort_count0", cnt0, 28);
    check_output("abort_count3", cnt3, saved3);
    check_output("abort_mask_valid0", mask_valid0, 0);
    check_output("abort_busy0", busy0, 1);
    check_output("abort_mask_valid3", mask_valid3, 0);
    check_output("abort_busy3", busy3, 1);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk_sys);
    osd_rotate = 1'b1;
    repeat (5) @(negedge clk_sys);
    #1;
    check_output("no_refresh_after_abort0", cnt0, 28);
    check_output("no_refresh_after_abort3", cnt3, saved3);

    $display("[TB] reset mid-send");
    clear_counters();
    expect_file();
    apply_stimulus(-1);
    wait_strobes0(10, 200);
    check_output("reset_point", cnt0, 10);
    reset_n = 1'b0;
    #1;
    check_idle("async_reset");
    q0.delete();
    q3.delete();
    saved3 = cnt3;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    #1;
    check_output("post_reset_count0", cnt0, 10);
    check_output("post_reset_count3", cnt3, saved3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
